// File: rtl/addecrc.sv
// addecrc -- appends an IEEE 802.3 CRC-32 trailer to a nibble-wide frame
// stream. It can also pass the frame through unchanged, with one registered
// stage of delay.
//
// Each frame is echoed one i_ce cycle late. In append mode, eight trailer
// nibbles follow the last data nibble with no gap. They hold the complemented
// CRC, least significant byte first and low nibble first.
//
// Ports:
//   i_clk      rising-edge clock for all state
//   i_reset    synchronous active-high reset (wins over i_ce and i_cancel)
//   i_ce       nibble-rate clock enable; everything holds while low
//   i_en       1 = append CRC, 0 = registered bypass; sampled at frame start
//   i_cancel   abort the current frame
//   i_v        input nibble valid; a frame is one contiguous run of i_v high
//   i_nibble   input nibble, low nibble of each byte first
//   o_v        output nibble valid (registered)
//   o_nibble   output nibble (registered)
module addecrc (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ce,
  input  logic       i_en,
  input  logic       i_cancel,
  input  logic       i_v,
  input  logic [3:0] i_nibble,
  output logic       o_v,
  output logic [3:0] o_nibble
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TRAIL,
    WAIT
  } state_t;

  localparam logic [31:0] CrcInit = 32'hFFFF_FFFF;
  localparam logic [31:0] CrcPoly = 32'hEDB8_8320;

  state_t      state_q,     state_d;
  logic [2:0]  count_q,     count_d;
  logic [31:0] crc_q,       crc_d;
  logic        enLatch_q,   enLatch_d;
  logic        outValid_q,  outValid_d;
  logic [3:0]  outNibble_q, outNibble_d;

  // Advances the reflected CRC-32 LFSR by one nibble, consuming bit 0 first.
  // This matches the byte-wise reflected CRC when the low nibble goes first.
  function automatic logic [31:0] crcNibble(input logic [31:0] crc,
                                            input logic [3:0]  d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 4; i++) begin
      if (c[0] ^ d[i]) begin
        c = (c >> 1) ^ CrcPoly;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  // Next-state logic for the framer. Cancel is checked first so that it
  // overrides every other transition in the same cycle. A frame only starts
  // from IDLE, which is reached only after i_v has been seen low. This keeps
  // us from ever picking up the tail end of a run we did not see start. The
  // first nibble of a frame seeds the CRC from the constant initial value.
  // A frame that starts right after a trailer or a bypass frame therefore
  // never depends on a leftover register value.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    crc_d       = crc_q;
    enLatch_d   = enLatch_q;
    outValid_d  = outValid_q;
    outNibble_d = outNibble_q;

    if (i_cancel) begin
      outValid_d = 1'b0;
      crc_d      = CrcInit;
      count_d    = 3'd0;
      state_d    = i_v ? WAIT : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_v) begin
            enLatch_d   = i_en;
            state_d     = DATA;
            outValid_d  = 1'b1;
            outNibble_d = i_nibble;
            crc_d       = crcNibble(CrcInit, i_nibble);
          end else begin
            outValid_d = 1'b0;
            crc_d      = CrcInit;
          end
        end

        DATA: begin
          if (!enLatch_q) begin
            outValid_d  = i_v;
            outNibble_d = i_nibble;
            if (!i_v) begin
              state_d = IDLE;
              crc_d   = CrcInit;
            end
          end else if (i_v) begin
            outValid_d  = 1'b1;
            outNibble_d = i_nibble;
            crc_d       = crcNibble(crc_q, i_nibble);
          end else begin
            state_d     = TRAIL;
            count_d     = 3'd1;
            outValid_d  = 1'b1;
            outNibble_d = ~crc_q[3:0];
          end
        end

        TRAIL: begin
          // Any i_v activity here is discarded. If a run is still active
          // when the last trailer nibble goes out, we wait for it to end.
          outValid_d  = 1'b1;
          outNibble_d = ~crc_q[{count_q, 2'b00} +: 4];
          if (count_q == 3'd7) begin
            count_d = 3'd0;
            state_d = i_v ? WAIT : IDLE;
          end else begin
            count_d = count_q + 3'd1;
          end
        end

        WAIT: begin
          outValid_d = 1'b0;
          if (!i_v) begin
            state_d = IDLE;
            crc_d   = CrcInit;
          end
        end

        default: begin
          outValid_d = 1'b0;
          state_d    = WAIT;
        end
      endcase
    end
  end

  // State register. Reset parks the block in WAIT. After reset, output
  // resumes only with a frame that starts after i_v has been seen low.
  // All updates are gated by the nibble-rate enable.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= WAIT;
      count_q     <= 3'd0;
      crc_q       <= CrcInit;
      enLatch_q   <= 1'b0;
      outValid_q  <= 1'b0;
      outNibble_q <= 4'h0;
    end else if (i_ce) begin
      state_q     <= state_d;
      count_q     <= count_d;
      crc_q       <= crc_d;
      enLatch_q   <= enLatch_d;
      outValid_q  <= outValid_d;
      outNibble_q <= outNibble_d;
    end
  end

  assign o_v      = outValid_q;
  assign o_nibble = outNibble_q;

endmodule

// File: tb/tb_addecrc.sv
// tb_addecrc -- directed testbench for addecrc. Each scenario task drives its
// own stimulus and compares the registered outputs against hand-computed
// nibble sequences (ASCII "123456789" -> CRC 0xCBF43926, single nibble 0x0 ->
// CRC 0x4DBDF21C).
module tb_addecrc;

  logic       clk;
  logic       reset;
  logic       ce;
  logic       en;
  logic       cancel;
  logic       v;
  logic [3:0] nibble;
  logic       outV;
  logic [3:0] outNibble;

  int total;
  int bad;

  logic [3:0] msgNib    [0:17];
  logic [3:0] goodTrail [0:7];
  logic [3:0] zeroTrail [0:7];
  logic [3:0] bypassNib [0:9];
  logic [3:0] heldNib;

  addecrc dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_ce     (ce),
    .i_en     (en),
    .i_cancel (cancel),
    .i_v      (v),
    .i_nibble (nibble),
    .o_v      (outV),
    .o_nibble (outNibble)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle a little past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset state, reset priority over i_ce/i_cancel, and the WAIT state that
  // reset leaves behind while i_v is still high.
  task automatic test_reset();
    reset = 1'b1; ce = 1'b0; en = 1'b1; cancel = 1'b0; v = 1'b0; nibble = 4'h0;
    tick();
    total++;
    if ({outV, outNibble} !== 5'h00) begin
      bad++;
      $display("[TB] FAIL reset_ce_low: got v=%0b nib=%h, want v=0 nib=0", outV, outNibble);
    end
    ce = 1'b1; cancel = 1'b1; v = 1'b1; nibble = 4'h9;
    tick();
    total++;
    if ({outV, outNibble} !== 5'h00) begin
      bad++;
      $display("[TB] FAIL reset_priority: got v=%0b nib=%h, want v=0 nib=0", outV, outNibble);
    end
    reset = 1'b0; cancel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (outV !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_wait_%0d: got v=%0b, want v=0", i, outV);
      end
    end
    v = 1'b0;
    tick();
    total++;
    if (outV !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_to_idle: got v=%0b, want v=0", outV);
    end
  endtask

  // "123456789" with the enable high on every cycle: data echoed, then CRC.
  task automatic test_crc_frame();
    en = 1'b1; ce = 1'b1;
    for (int i = 0; i < 18; i++) begin
      v = 1'b1; nibble = msgNib[i];
      tick();
      total++;
      if ({outV, outNibble} !== {1'b1, msgNib[i]}) begin
        bad++;
        $display("[TB] FAIL crc_data_%0d: got v=%0b nib=%h, want v=1 nib=%h", i, outV, outNibble, msgNib[i]);
      end
    end
    v = 1'b0; nibble = 4'h0;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if ({outV, outNibble} !== {1'b1, goodTrail[i]}) begin
        bad++;
        $display("[TB] FAIL crc_trail_%0d: got v=%0b nib=%h, want v=1 nib=%h", i, outV, outNibble, goodTrail[i]);
      end
    end
    tick();
    total++;
    if (outV !== 1'b0) begin
      bad++;
      $display("[TB] FAIL crc_end: got v=%0b, want v=0", outV);
    end
  endtask

  // A one-nibble frame still gets its full eight-nibble trailer.
  task automatic test_single_nibble();
    en = 1'b1; ce = 1'b1; v = 1'b1; nibble = 4'h0;
    tick();
    total++;
    if ({outV, outNibble} !== 5'h10) begin
      bad++;
      $display("[TB] FAIL single_data: got v=%0b nib=%h, want v=1 nib=0", outV, outNibble);
    end
    v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if ({outV, outNibble} !== {1'b1, zeroTrail[i]}) begin
        bad++;
        $display("[TB] FAIL single_trail_%0d: got v=%0b nib=%h, want v=1 nib=%h", i, outV, outNibble, zeroTrail[i]);
      end
    end
    tick();
    total++;
    if (outV !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_end: got v=%0b, want v=0", outV);
    end
  endtask

  // Same frame with i_ce high one cycle in three. On the idle cycles, junk
  // is driven on the inputs and the outputs must hold.
  task automatic test_ce_third();
    en = 1'b1;
    for (int i = 0; i < 26; i++) begin
      ce = 1'b1; cancel = 1'b0;
      v = (i < 18) ? 1'b1 : 1'b0;
      nibble = (i < 18) ? msgNib[i] : 4'h0;
      heldNib = (i < 18) ? msgNib[i] : goodTrail[i - 18];
      tick();
      total++;
      if ({outV, outNibble} !== {1'b1, heldNib}) begin
        bad++;
        $display("[TB] FAIL ce_nib_%0d: got v=%0b nib=%h, want v=1 nib=%h", i, outV, outNibble, heldNib);
      end
      ce = 1'b0; v = 1'b0; nibble = 4'hE; cancel = 1'b1;
      for (int k = 0; k < 2; k++) begin
        tick();
        total++;
        if ({outV, outNibble} !== {1'b1, heldNib}) begin
          bad++;
          $display("[TB] FAIL ce_hold_%0d_%0d: got v=%0b nib=%h, want v=1 nib=%h", i, k, outV, outNibble, heldNib);
        end
      end
    end
    cancel = 1'b0; ce = 1'b1; v = 1'b0;
    tick();
    total++;
    if (outV !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ce_end: got v=%0b, want v=0", outV);
    end
  endtask

  // Bypass: ten nibbles out, no trailer. i_en rising mid-frame is ignored.
  task automatic test_bypass();
    ce = 1'b1; en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      v = 1'b1; nibble = bypassNib[i];
      tick();
      en = 1'b1;
      total++;
      if ({outV, outNibble} !== {1'b1, bypassNib[i]}) begin
        bad++;
        $display("[TB] FAIL bypass_data_%0d: got v=%0b nib=%h, want v=1 nib=%h", i, outV, outNibble, bypassNib[i]);
      end
    end
    v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (outV !== 1'b0) begin
        bad++;
        $display("[TB] FAIL bypass_no_trail_%0d: got v=%0b, want v=0", i, outV);
      end
    end
  endtask

  // Cancel at data nibble 5. The run keeps going, but nothing is output
  // until i_v drops. The following frame must carry a correct CRC.
  task automatic test_cancel();
    ce = 1'b1; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v = 1'b1; nibble = msgNib[i];
      tick();
      total++;
      if ({outV, outNibble} !== {1'b1, msgNib[i]}) begin
        bad++;
        $display("[TB] FAIL cancel_pre_%0d: got v=%0b nib=%h, want v=1 nib=%h", i, outV, outNibble, msgNib[i]);
      end
    end
    for (int i = 5; i < 11; i++) begin
      cancel = (i == 5);
      v = (i < 10);
      nibble = msgNib[i];
      tick();
      total++;
      if (outV !== 1'b0) begin
        bad++;
        $display("[TB] FAIL cancel_quiet_%0d: got v=%0b, want v=0", i, outV);
      end
    end
    cancel = 1'b0;
    for (int i = 0; i < 27; i++) begin
      v = (i < 18);
      nibble = (i < 18) ? msgNib[i] : 4'h0;
      tick();
      if (i >= 18 && i < 26) begin
        total++;
        if ({outV, outNibble} !== {1'b1, goodTrail[i - 18]}) begin
          bad++;
          $display("[TB] FAIL cancel_next_trail_%0d: got v=%0b nib=%h, want v=1 nib=%h", i - 18, outV, outNibble, goodTrail[i - 18]);
        end
      end
    end
  endtask

  // A new run starts one cycle after the last data nibble. The trailer
  // completes untouched, the overlapping nibbles are dropped, and the block
  // waits for i_v to go low.
  task automatic test_back_to_back();
    ce = 1'b1; en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      v = 1'b1; nibble = msgNib[i];
      tick();
      total++;
      if ({outV, outNibble} !== {1'b1, msgNib[i]}) begin
        bad++;
        $display("[TB] FAIL b2b_data_%0d: got v=%0b nib=%h, want v=1 nib=%h", i, outV, outNibble, msgNib[i]);
      end
    end
    v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      v = 1'b1; nibble = 4'h5;
      total++;
      if ({outV, outNibble} !== {1'b1, goodTrail[i]}) begin
        bad++;
        $display("[TB] FAIL b2b_trail_%0d: got v=%0b nib=%h, want v=1 nib=%h", i, outV, outNibble, goodTrail[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 3) v = 1'b0;
      tick();
      total++;
      if (outV !== 1'b0) begin
        bad++;
        $display("[TB] FAIL b2b_wait_%0d: got v=%0b, want v=0", i, outV);
      end
    end
  endtask

  // Reset during the trailer at nibble 3, then a clean frame.
  task automatic test_reset_trail();
    ce = 1'b1; en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      v = 1'b1; nibble = msgNib[i];
      tick();
    end
    v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({outV, outNibble} !== {1'b1, goodTrail[i]}) begin
        bad++;
        $display("[TB] FAIL rst_trail_%0d: got v=%0b nib=%h, want v=1 nib=%h", i, outV, outNibble, goodTrail[i]);
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({outV, outNibble} !== 5'h00) begin
      bad++;
      $display("[TB] FAIL rst_trail_cut: got v=%0b nib=%h, want v=0 nib=0", outV, outNibble);
    end
    tick();
    total++;
    if (outV !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_trail_idle: got v=%0b, want v=0", outV);
    end
    for (int i = 0; i < 27; i++) begin
      v = (i < 18);
      nibble = (i < 18) ? msgNib[i] : 4'h0;
      heldNib = (i < 18) ? msgNib[i] : ((i < 26) ? goodTrail[i - 18] : 4'h0);
      tick();
      total++;
      if (i < 26 && {outV, outNibble} !== {1'b1, heldNib}) begin
        bad++;
        $display("[TB] FAIL rst_next_%0d: got v=%0b nib=%h, want v=1 nib=%h", i, outV, outNibble, heldNib);
      end else if (i == 26 && outV !== 1'b0) begin
        bad++;
        $display("[TB] FAIL rst_next_end: got v=%0b, want v=0", outV);
      end
    end
  endtask

  // Build the stimulus tables, then run each scenario in order.
  initial begin
    total = 0;
    bad   = 0;
    for (int k = 0; k < 9; k++) begin
      logic [7:0] ch;
      ch = 8'h31 + 8'(k);
      msgNib[2*k]   = ch[3:0];
      msgNib[2*k+1] = ch[7:4];
    end
    goodTrail = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
    zeroTrail = '{4'hC, 4'h1, 4'h2, 4'hF, 4'hD, 4'hB, 4'hD, 4'h4};
    bypassNib = '{4'hA, 4'h5, 4'h0, 4'hF, 4'h1, 4'hE, 4'h7, 4'h8, 4'hC, 4'h3};
    heldNib   = 4'h0;

    test_reset();
    test_crc_frame();
    test_single_nibble();
    test_ce_third();
    test_bypass();
    test_cancel();
    test_back_to_back();
    test_reset_trail();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
